// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package rf_dump_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_FIN
    } state_t;

    localparam int CNT_W = 3;

    // Upper bits of the index byte that precedes each register's data.
    localparam logic [2:0] IDX_PREFIX = 3'b000;

endpackage

// File: rtl/word_serializer.sv
// Holds one captured register word and presents it as a byte sequence,
// keeping the presented byte stable until the transmitter accepts it.
module word_serializer
    import rf_dump_pkg::*;
#(
    parameter int SEND_INDEX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic        active,
    input  logic [4:0]  index,
    input  logic [31:0] din,
    output logic [7:0]  tx_data,
    output logic        last
);

    localparam logic [CNT_W-1:0] TERM = (SEND_INDEX != 0) ? 3'd4 : 3'd3;

    logic [31:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_sel;

    assign last = (cnt_q == TERM);

    // The counter only moves on an accepted byte, so a stall holds tx_data.
    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if (load) begin
            snap_d = din;
            cnt_d  = '0;
        end else if (advance && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    generate
        if (SEND_INDEX != 0) begin : g_with_index
            logic [CNT_W-1:0] data_idx;
            always_comb begin
                data_idx = cnt_q - 1'b1;
                byte_sel = snap_q[7:0];
                if (cnt_q == '0) begin
                    byte_sel = {IDX_PREFIX, index};
                end else begin
                    case (data_idx[1:0])
                        2'd0:    byte_sel = snap_q[7:0];
                        2'd1:    byte_sel = snap_q[15:8];
                        2'd2:    byte_sel = snap_q[23:16];
                        default: byte_sel = snap_q[31:24];
                    endcase
                end
            end
        end else begin : g_data_only
            always_comb begin
                case (cnt_q[1:0])
                    2'd0:    byte_sel = snap_q[7:0];
                    2'd1:    byte_sel = snap_q[15:8];
                    2'd2:    byte_sel = snap_q[23:16];
                    default: byte_sel = snap_q[31:24];
                endcase
            end
        end
    endgenerate

    assign tx_data = active ? byte_sel : 8'h00;

endmodule

// File: rtl/rf_dump_engine.sv
// Walks the register file through its debug read port and streams every
// register out as bytes; legal NUM_REGS range is 1..32.
module rf_dump_engine
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int SEND_INDEX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  addr,
    input  logic [31:0] dout_rf,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    state_t     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic       load;
    logic       xfer;
    logic       last;
    logic       sending;

    assign sending = (state_q == S_SEND);
    assign xfer    = sending && tx_ready;
    assign addr    = addr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        load     = 1'b0;
        tx_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy   = 1'b0;
                addr_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && last) begin
                    // Stop on the final register rather than letting addr wrap.
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    word_serializer #(
        .SEND_INDEX(SEND_INDEX)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .advance(xfer),
        .active (sending),
        .index  (addr_q),
        .din    (dout_rf),
        .tx_data(tx_data),
        .last   (last)
    );

endmodule

// File: tb/tb_rf_dump_engine.sv
// Bench for rf_dump_engine: a default 32-register instance and a
// single-register instance without index bytes, checked against a byte scoreboard.
module tb_rf_dump_engine;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start, tx_ready;
    logic [4:0]  addr;
    logic [31:0] dout_rf;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    logic        start1, tx_ready1;
    logic [4:0]  addr1;
    logic [31:0] dout_rf1;
    logic [7:0]  tx_data1;
    logic        tx_valid1, busy1, done1;

    logic [31:0] rf [32];
    logic [31:0] rf1_0;

    assign dout_rf  = rf[addr];
    assign dout_rf1 = (addr1 == 5'd0) ? rf1_0 : 32'hFFFF_FFFF;

    rf_dump_engine dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .dout_rf(dout_rf),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    rf_dump_engine #(.NUM_REGS(1), .SEND_INDEX(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .addr(addr1), .dout_rf(dout_rf1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] obs1_q[$];

    // Monitor: records accepted bytes and protocol observations; tasks judge them.
    int         done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    int         stall_err = 0, wrap_err = 0;
    int         done1_cnt = 0, done1_cyc = 0, addr1_err = 0;
    logic       busy_at_done = 1'b0;
    logic       prev_stall = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [4:0] prev_addr = 5'd0;

    always @(negedge clk) begin
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (busy && prev_busy && addr < prev_addr) wrap_err++;
        prev_busy = busy;
        prev_addr = addr;
        if (tx_valid && tx_ready) begin
            obs_q.push_back(tx_data);
            last_xfer_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (addr1 !== 5'd0) addr1_err++;
        if (tx_valid1 && tx_ready1) obs1_q.push_back(tx_data1);
        if (done1) begin
            done1_cnt++;
            done1_cyc = cyc;
        end
    end

    task automatic push_reg(input logic [4:0] idx, input logic [31:0] w);
        exp_q.push_back({3'b000, idx});
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic build_default_expect();
        exp_q.delete();
        for (int i = 0; i < 32; i++) push_reg(5'(i), rf[i]);
    endtask

    task automatic pulse_start(output int c0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input bit toggle, output bit timed_out);
        int d0 = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (toggle) tx_ready = ~tx_ready;
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1; start1 = 1'b0; tx_ready1 = 1'b1;
        @(posedge clk); #1;
        got = {tx_valid, busy, done, addr, tx_data, 1'b0};
        n_cmp++;
        if (got !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", got);
        end
        got = {tx_valid1, busy1, done1, addr1, tx_data1, 1'b0};
        n_cmp++;
        if (got !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs_1reg: got %h required 0", got);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        int c0, w0;
        bit to;
        logic [7:0] e, g;
        w0 = wrap_err;
        build_default_expect();
        obs_q.delete();
        tx_ready = 1'b1;
        pulse_start(c0);
        n_cmp++;
        if (busy !== 1'b1 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_cycle: busy=%b tx_valid=%b required 1/0", busy, tx_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL first_byte_latency: valid=%b data=%h required 1/00", tx_valid, tx_data);
        end
        wait_done(1'b0, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL full_dump_timeout: no done within bound");
        end
        n_cmp++;
        if (obs_q.size() != 160) begin
            n_err++;
            $display("FAIL full_dump_count: got %0d required 160", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL full_dump_byte[%0d]: got %h required %h", i, g, e);
            end
        end
        n_cmp++;
        if (done_cyc - c0 != 192) begin
            n_err++;
            $display("FAIL load_to_fin_cycles: got %0d required 192", done_cyc - c0);
        end
        n_cmp++;
        if (done_cyc != last_xfer_cyc + 1) begin
            n_err++;
            $display("FAIL done_after_last: got %0d required %0d", done_cyc, last_xfer_cyc + 1);
        end
        n_cmp++;
        if (busy_at_done !== 1'b1 || addr !== 5'd31) begin
            n_err++;
            $display("FAIL fin_state: busy=%b addr=%0d required 1/31", busy_at_done, addr);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle: busy=%b done=%b valid=%b required 0/0/0", busy, done, tx_valid);
        end
        n_cmp++;
        if (wrap_err != w0) begin
            n_err++;
            $display("FAIL addr_monotonic: got %0d decreases required 0", wrap_err - w0);
        end
    endtask

    task automatic test_stall_toggle();
        int c0, s0;
        bit to;
        logic [7:0] e, g;
        s0 = stall_err;
        build_default_expect();
        obs_q.delete();
        tx_ready = 1'b1;
        pulse_start(c0);
        wait_done(1'b1, to);
        tx_ready = 1'b1;
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL toggle_timeout: no done within bound");
        end
        n_cmp++;
        if (obs_q.size() != 160) begin
            n_err++;
            $display("FAIL toggle_count: got %0d required 160", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL toggle_byte[%0d]: got %h required %h", i, g, e);
            end
        end
        n_cmp++;
        if (stall_err != s0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d changes while stalled required 0", stall_err - s0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_snapshot();
        int c0, d0;
        bit stalled;
        logic [7:0] e, g;
        logic [31:0] keep5, keep6;
        keep5 = rf[5];
        keep6 = rf[6];
        exp_q.delete();
        for (int i = 0; i < 32; i++) push_reg(5'(i), (i == 6) ? 32'hCAFE_F00D : rf[i]);
        obs_q.delete();
        tx_ready = 1'b1;
        stalled = 1'b0;
        d0 = done_cnt;
        pulse_start(c0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            if (!stalled && obs_q.size() == 27) begin
                stalled  = 1'b1;
                tx_ready = 1'b0;
                @(posedge clk); #1;
                rf[5] = 32'hDEAD_BEEF;
                rf[6] = 32'hCAFE_F00D;
                @(posedge clk); #1;
                n_cmp++;
                if (tx_data !== 8'h00 || addr !== 5'd5) begin
                    n_err++;
                    $display("FAIL snapshot_stalled: data=%h addr=%0d required 00/5", tx_data, addr);
                end
                tx_ready = 1'b1;
            end
        end
        n_cmp++;
        if (done_cnt == d0 || !stalled) begin
            n_err++;
            $display("FAIL snapshot_run: done=%0d stalled=%b required done and stall", done_cnt - d0, stalled);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            if (i >= 25 && i < 35) begin
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL snapshot_byte[%0d]: got %h required %h", i, g, e);
                end
            end
        end
        rf[5] = keep5;
        rf[6] = keep6;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int c0, d0;
        bit p1, p2;
        logic [7:0] e, g;
        build_default_expect();
        obs_q.delete();
        tx_ready = 1'b1;
        p1 = 1'b0;
        p2 = 1'b0;
        d0 = done_cnt;
        pulse_start(c0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (!p1 && obs_q.size() == 40) begin
                p1 = 1'b1;
                start = 1'b1;
            end
            if (!p2 && obs_q.size() == 160 && done === 1'b1) begin
                p2 = 1'b1;
                start = 1'b1;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!p2) begin
            n_err++;
            $display("FAIL start_in_fin: done not seen with 160 bytes sent, got %0d bytes", obs_q.size());
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL single_done: got %0d pulses required 1", done_cnt - d0);
        end
        n_cmp++;
        if (obs_q.size() != 160 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL no_second_dump: bytes=%0d busy=%b required 160/0", obs_q.size(), busy);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            if (g !== e) begin
                n_cmp++;
                n_err++;
                $display("FAIL ignored_start_byte[%0d]: got %h required %h", i, g, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        int c0, d0;
        bit to, hit;
        logic [7:0] e, g;
        logic [14:0] got;
        obs_q.delete();
        tx_ready = 1'b1;
        d0 = done_cnt;
        hit = 1'b0;
        pulse_start(c0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (obs_q.size() == 52) begin
                hit = 1'b1;
                break;
            end
        end
        #2 rst = 1'b1;
        #1;
        got = {tx_valid, busy, done, addr, tx_data};
        n_cmp++;
        if (!hit || got !== 15'd0) begin
            n_err++;
            $display("FAIL async_reset_abort: reached=%b got %h required 0", hit, got);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done=%0d busy=%b required 0/0", done_cnt - d0, busy);
        end
        build_default_expect();
        obs_q.delete();
        pulse_start(c0);
        wait_done(1'b0, to);
        n_cmp++;
        if (to || obs_q.size() != 160) begin
            n_err++;
            $display("FAIL restart_count: timeout=%b bytes=%0d required 0/160", to, obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            if (i < 10 || g !== e) begin
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL restart_byte[%0d]: got %h required %h", i, g, e);
                end
            end
        end
    endtask

    task automatic test_single_reg();
        int c0, d0;
        bit to;
        logic [7:0] exp1 [4];
        logic [7:0] g;
        exp1[0] = 8'h02; exp1[1] = 8'h01; exp1[2] = 8'hA5; exp1[3] = 8'hA5;
        rf1_0 = 32'hA5A5_0102;
        obs1_q.delete();
        tx_ready1 = 1'b1;
        d0 = done1_cnt;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        c0 = cyc;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done1_cnt != d0) begin
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to || obs1_q.size() != 4) begin
            n_err++;
            $display("FAIL single_reg_count: timeout=%b bytes=%0d required 0/4", to, obs1_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            g = (obs1_q.size() > 0) ? obs1_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== exp1[i]) begin
                n_err++;
                $display("FAIL single_reg_byte[%0d]: got %h required %h", i, g, exp1[i]);
            end
        end
        n_cmp++;
        if (done1_cyc - c0 != 5) begin
            n_err++;
            $display("FAIL single_reg_cycles: got %0d required 5", done1_cyc - c0);
        end
        n_cmp++;
        if (addr1_err != 0) begin
            n_err++;
            $display("FAIL single_reg_addr: got %0d nonzero samples required 0", addr1_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf1_0 = 32'h0;
        test_reset();
        test_full_dump();
        test_stall_toggle();
        test_snapshot();
        test_start_ignored();
        test_reset_abort();
        test_single_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_dump_engine.md
RF_DUMP_ENGINE -- requirements
Module: rf_dump_engine

Interface
REQ-001 Parameter NUM_REGS, default 32: registers dumped, indices 0..NUM_REGS-1; legal range 1..32.
REQ-002 Parameter SEND_INDEX, default 1: when 1, each register's data bytes are preceded by an index byte {3'b000, addr}.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  dump request, sampled at posedge clk; ignored while busy=1.
REQ-006 addr  output  5  register-file debug read address.
REQ-007 dout_rf  input  32  register-file debug read data; combinational from addr in the same cycle.
REQ-008 tx_data  output  8  byte-stream data to the SDU transmitter.
REQ-009 tx_valid  output  1  tx_data holds a valid byte.
REQ-010 tx_ready  input  1  transmitter accepts the byte; a transfer occurs on a posedge with tx_valid=1 and tx_ready=1.
REQ-011 busy  output  1  high from the cycle after start is accepted until the cycle after done.
REQ-012 done  output  1  one-cycle pulse when the final byte has transferred.

Function
REQ-013 FSM states: IDLE, LOAD, SEND, FIN.
REQ-014 IDLE: addr=0, tx_valid=0, busy=0; start=1 -> LOAD with addr=0.
REQ-015 LOAD: one cycle, tx_valid=0; at the posedge, dout_rf is captured into a 32-bit snapshot, byte counter cleared, -> SEND.
REQ-016 SEND: tx_valid=1; byte order per register: index byte (if SEND_INDEX), then data[7:0], [15:8], [23:16], [31:24].
REQ-017 Each transfer advances the byte counter; without a transfer, tx_data and tx_valid hold unchanged (no retraction, no change while stalled).
REQ-018 Transfer of the last byte of a register: if addr==NUM_REGS-1 -> FIN; else addr increments by 1 -> LOAD.
REQ-019 FIN: done=1 and busy=1 for exactly one cycle; tx_valid=0; -> IDLE.
REQ-020 Latency: start sampled at edge E0 -> LOAD during E0..E1 -> tx_valid=1 after E1.
REQ-021 Throughput with tx_ready held 1: (1 + 4 + SEND_INDEX) cycles per register; NUM_REGS=32, SEND_INDEX=1 -> 192 cycles from LOAD entry to FIN entry.
REQ-022 Snapshot rule: register-file writes after the LOAD capture do not alter bytes of the word in flight; writes to later registers before their LOAD are reflected.
REQ-023 start asserted while busy=1, including during FIN, is dropped, not queued.
REQ-024 addr never exceeds NUM_REGS-1; no wrap to 0 within a dump.
REQ-025 Byte counter width: 3 bits; terminal count 4 when SEND_INDEX=1, 3 when SEND_INDEX=0.

Reset
REQ-026 rst=1 forces immediately, without waiting for clk: state=IDLE, addr=0, tx_valid=0, tx_data=0, busy=0, done=0, snapshot=0, byte counter=0.
REQ-027 Reset during SEND aborts the dump; the partial byte stream is not resumed, and done is not pulsed.
REQ-028 After rst deasserts, the first start is accepted normally.

Structure
REQ-029 Shared package rf_dump_pkg holds the state enum typedef, the byte-counter width, and the index-byte prefix constant 3'b000.
REQ-030 One sub-module, word_serializer: snapshot register, byte counter, tx_data mux, and hold-while-stalled logic; the FSM and addr counter stay in rf_dump_engine.

Verification
REQ-031 Regfile model with rf[i]=32'h1000_0000+i, start pulse, tx_ready=1 -> stream 00 00 00 00 10, 01 01 00 00 10, ... 1F 1F 00 00 10 (160 bytes); done one cycle after the last byte; 192 cycles LOAD..FIN.
REQ-032 Same setup with tx_ready toggling 1,0,1,0 -> identical byte stream; tx_data stable during every stalled cycle.
REQ-033 rf[5] written to 32'hDEAD_BEEF while register 5's byte 2 is stalled, capture held 32'h1000_0005 -> bytes 05 05 00 00 10 sent unchanged; rf[6] written before its LOAD -> new value sent.
REQ-034 start pulsed again at byte 40 and during FIN -> no second dump; exactly 160 bytes; one done pulse.
REQ-035 rst asserted mid-register 10, between clock edges -> tx_valid, busy, addr go to 0 before the next edge; no done; a new start gives a full dump from register 0.
REQ-036 NUM_REGS=1, SEND_INDEX=0, rf[0]=32'hA5A5_0102 -> bytes 02 01 A5 A5, then done; addr stays 0 throughout.
